// File: rtl/capture_fifo_mcu_reader_pkg.sv
// Shared types and constants for the capture FIFO MCU reader.
// Register map, FSM encoding, underflow word, saturating helper.
package capture_fifo_mcu_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_READ    = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_TS_SEC_LO = 3'd1;
  localparam logic [2:0] ADDR_TS_SEC_HI = 3'd2;
  localparam logic [2:0] ADDR_TS_SUB_LO = 3'd3;
  localparam logic [2:0] ADDR_TS_SUB_HI = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_WORDS     = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  localparam logic [15:0] UNDERFLOW_WORD = 16'hFFFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/capture_fifo_mcu_reader_if.sv
// FIFO read side and MCU register read bus of the capture reader.
// slave: the reader; master: the FIFO/MCU side.
interface capture_fifo_mcu_reader_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic              fifo_idle;
  logic              mcu_rd_stb;
  logic [2:0]        mcu_addr;
  logic [15:0]       mcu_rd_data;
  logic              mcu_rd_ack;
  logic              irq;

  modport slave (
    input  fifo_rd_data, fifo_empty,
    input  mcu_rd_stb, mcu_addr,
    output fifo_rd_en, fifo_idle,
    output mcu_rd_data, mcu_rd_ack, irq
  );

  modport master (
    output fifo_rd_data, fifo_empty,
    output mcu_rd_stb, mcu_addr,
    input  fifo_rd_en, fifo_idle,
    input  mcu_rd_data, mcu_rd_ack, irq
  );
endinterface

// File: rtl/capture_fifo_mcu_reader_sec_edge_det.sv
// Synchronises one_second_clk (2 FF) and emits a one-cycle pulse
// per rising edge. Ports: clk_100m, reset_n, one_second_clk, sec_pulse.
module sec_edge_det (
  input  logic clk_100m,
  input  logic reset_n,
  input  logic one_second_clk,
  output logic sec_pulse
);
  logic [2:0] sh;

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) sh <= 3'b000;
    else          sh <= {sh[1:0], one_second_clk};
  end

  assign sec_pulse = sh[1] & ~sh[2];
endmodule

// File: rtl/capture_fifo_mcu_reader.sv
// Reads completed capture records out of the FIFO for the MCU.
// Ports: clk_100m, reset_n, capture/time inputs, bus (FIFO + MCU).
module capture_fifo_mcu_reader
  import capture_fifo_mcu_reader_pkg::*;
#(
  parameter int RECORD_LEN = 4096,
  parameter int DATA_W     = 12,
  parameter int TIMEOUT_S  = 10,
  parameter int CNT_W      = 13
) (
  input  logic        clk_100m,
  input  logic        reset_n,
  input  logic        start_time_flag,
  input  logic        record_done,
  input  logic        one_second_clk,
  input  logic [31:0] sec_cnt,
  input  logic [26:0] subsec_cnt,
  capture_fifo_mcu_reader_if.slave bus
);
  localparam int IS_W = $clog2(TIMEOUT_S + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  words_left;
  logic [IS_W-1:0]   idle_sec;
  logic [7:0]        missed_cnt, flush_cnt;
  logic              underflow, irq_q;
  logic [31:0]       ts_sec;
  logic [26:0]       ts_sub;
  logic [15:0]       rd_data_q, rd_mux;
  logic              ack_q;
  logic              sec_pulse;
  logic              busy, data_rd, pop_ok, timeout;

  sec_edge_det u_sec (
    .clk_100m       (clk_100m),
    .reset_n        (reset_n),
    .one_second_clk (one_second_clk),
    .sec_pulse      (sec_pulse)
  );

  assign busy    = (state == ST_PENDING) || (state == ST_READ);
  assign data_rd = bus.mcu_rd_stb && (bus.mcu_addr == ADDR_DATA);
  assign pop_ok  = data_rd && busy && !bus.fifo_empty
                   && (words_left != '0);
  // A strobe in the timeout cycle wins: it clears idle_sec instead.
  assign timeout = busy && !bus.mcu_rd_stb
                   && (idle_sec == TIMEOUT_S[IS_W-1:0]);

  assign bus.fifo_rd_en  = (state == ST_FLUSH) ? !bus.fifo_empty
                                               : pop_ok;
  assign bus.fifo_idle   = (state == ST_IDLE) && bus.fifo_empty;
  assign bus.mcu_rd_data = rd_data_q;
  assign bus.mcu_rd_ack  = ack_q;
  assign bus.irq         = irq_q;

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (record_done) state_nxt = ST_PENDING;
      ST_PENDING, ST_READ: begin
        if (pop_ok && words_left == CNT_W'(1)) state_nxt = ST_IDLE;
        else if (data_rd)                      state_nxt = ST_READ;
        else if (timeout)                      state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (bus.fifo_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 16'h0000;
    unique case (bus.mcu_addr)
      ADDR_DATA:
        rd_mux = pop_ok ? 16'(bus.fifo_rd_data) : UNDERFLOW_WORD;
      ADDR_TS_SEC_LO: rd_mux = ts_sec[15:0];
      ADDR_TS_SEC_HI: rd_mux = ts_sec[31:16];
      ADDR_TS_SUB_LO: rd_mux = ts_sub[15:0];
      ADDR_TS_SUB_HI: rd_mux = {5'b0, ts_sub[26:16]};
      ADDR_STATUS:
        rd_mux = {missed_cnt, flush_cnt[3:0], underflow, irq_q, state};
      ADDR_WORDS:     rd_mux = 16'(words_left);
      ADDR_RSVD:      rd_mux = 16'h0000;
      default:        rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      words_left <= '0;
      idle_sec   <= '0;
      missed_cnt <= '0;
      flush_cnt  <= '0;
      underflow  <= 1'b0;
      irq_q      <= 1'b0;
      ts_sec     <= '0;
      ts_sub     <= '0;
      rd_data_q  <= '0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= bus.mcu_rd_stb;
      if (bus.mcu_rd_stb) rd_data_q <= rd_mux;

      if (start_time_flag && state == ST_IDLE) begin
        ts_sec <= sec_cnt;
        ts_sub <= subsec_cnt;
      end

      if (state == ST_IDLE && record_done)
        words_left <= RECORD_LEN[CNT_W-1:0];
      else if (pop_ok)
        words_left <= words_left - CNT_W'(1);

      if (bus.mcu_rd_stb || !busy)
        idle_sec <= '0;
      else if (sec_pulse && idle_sec != TIMEOUT_S[IS_W-1:0])
        idle_sec <= idle_sec + IS_W'(1);

      irq_q <= (state_nxt == ST_PENDING);

      if (record_done && state != ST_IDLE)
        missed_cnt <= sat_inc8(missed_cnt);

      if (state != ST_FLUSH && state_nxt == ST_FLUSH)
        flush_cnt <= sat_inc8(flush_cnt);

      if (data_rd && !pop_ok && state != ST_IDLE)
        underflow <= 1'b1;
      else if (bus.mcu_rd_stb && bus.mcu_addr == ADDR_STATUS)
        underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_capture_fifo_mcu_reader.sv
// Bench for capture_fifo_mcu_reader: queue FIFO, reference
// model of the register view, directed and random reads.
module tb_capture_fifo_mcu_reader;
  localparam int RECORD_LEN = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_time_flag = 1'b0;
  logic        record_done = 1'b0;
  logic        one_second_clk = 1'b0;
  logic [31:0] sec_cnt = '0;
  logic [26:0] subsec_cnt = '0;

  capture_fifo_mcu_reader_if #(.DATA_W(12)) bus ();

  capture_fifo_mcu_reader dut (
    .clk_100m        (clk),
    .reset_n         (reset_n),
    .start_time_flag (start_time_flag),
    .record_done     (record_done),
    .one_second_clk  (one_second_clk),
    .sec_cnt         (sec_cnt),
    .subsec_cnt      (subsec_cnt),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  // show-ahead FIFO: ring memory, writer = initial, reader = DUT pops
  logic [11:0] mem [0:8191];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_data = mem[rd_ptr % 8192];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  int total = 0;
  int bad = 0;

  // reference model (register view of the reader)
  logic [11:0] exp_q[$];
  logic [1:0]  m_mode;
  logic        m_irq, m_under;
  logic [7:0]  m_missed, m_flush;
  int          m_words;
  logic [31:0] m_ts_sec;
  logic [26:0] m_ts_sub;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] exp;
    string       nm;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0; m_irq = 0; m_under = 0;
    m_missed = 0; m_flush = 0; m_words = 0;
    m_ts_sec = 0; m_ts_sub = 0;
  endtask

  task automatic model_record_done();
    if (m_mode == 0) begin
      m_mode = 1; m_irq = 1; m_words = RECORD_LEN;
    end else if (m_missed != 8'hFF) m_missed++;
  endtask

  task automatic model_flush();
    if (m_mode == 1 || m_mode == 2) begin
      m_mode = 0; m_irq = 0;
      if (m_flush != 8'hFF) m_flush++;
      exp_q.delete();
    end
  endtask

  task automatic model_read(input logic [2:0] a, output logic [15:0] r);
    r = 16'h0000;
    case (a)
      3'd0: begin
        if (m_mode == 1 || m_mode == 2) begin
          m_irq = 0;
          m_mode = 2;
          if (exp_q.size() > 0 && m_words > 0) begin
            r = {4'h0, exp_q.pop_front()};
            m_words--;
            if (m_words == 0) m_mode = 0;
          end else begin
            r = 16'hFFFF; m_under = 1;
          end
        end else begin
          r = 16'hFFFF;
          if (m_mode == 3) m_under = 1;
        end
      end
      3'd1: r = m_ts_sec[15:0];
      3'd2: r = m_ts_sec[31:16];
      3'd3: r = m_ts_sub[15:0];
      3'd4: r = {5'b0, m_ts_sub[26:16]};
      3'd5: begin
        r = {m_missed, m_flush[3:0], m_under, m_irq, m_mode};
        m_under = 0;
      end
      3'd6: r = 16'(m_words);
      default: r = 16'h0000;
    endcase
  endtask

  task automatic push(input logic [11:0] v);
    mem[wr_ptr % 8192] = v;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(v);
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d,
                    output logic ack);
    bus.mcu_addr = a;
    bus.mcu_rd_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mcu_rd_stb = 1'b0;
    d = bus.mcu_rd_data;
    ack = bus.mcu_rd_ack;
  endtask

  task automatic chk_read(input string nm, input logic [2:0] a,
                          output logic [15:0] d);
    logic [15:0] e;
    logic ack;
    rd(a, d, ack);
    model_read(a, e);
    chk({nm, " ack"}, ack, 1);
    chk(nm, d, e);
  endtask

  task automatic pulse_record_done();
    record_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    record_done = 1'b0;
    model_record_done();
  endtask

  task automatic tick();
    one_second_clk = 1'b1;
    repeat (4) @(negedge clk);
    one_second_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!bus.fifo_idle && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, bus.fifo_idle, 1);
  endtask

  initial begin
    logic [15:0] d, e;
    logic ack;
    int seen;

    tbl[0] = '{3'd1, 16'h2345, "ts_sec_lo"};
    tbl[1] = '{3'd2, 16'h0001, "ts_sec_hi"};
    tbl[2] = '{3'd3, 16'hCDEF, "ts_sub_lo"};
    tbl[3] = '{3'd4, 16'h03AB, "ts_sub_hi"};
    tbl[4] = '{3'd7, 16'h0000, "reserved"};
    tbl[5] = '{3'd6, 16'h1000, "words_left"};
    tbl[6] = '{3'd5, 16'h0005, "status_pending"};

    bus.mcu_rd_stb = 1'b0;
    bus.mcu_addr = 3'd0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst irq", bus.irq, 0);
    chk("rst ack", bus.mcu_rd_ack, 0);
    chk("rst data", bus.mcu_rd_data, 0);
    chk("rst rd_en", bus.fifo_rd_en, 0);
    chk("rst fifo_idle", bus.fifo_idle, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: timestamp and interrupt
    sec_cnt = 32'h0001_2345;
    subsec_cnt = 27'h3AB_CDEF;
    start_time_flag = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_time_flag = 1'b0;
    m_ts_sec = sec_cnt;
    m_ts_sub = subsec_cnt;
    sec_cnt = 32'hDEAD_BEEF;
    for (int i = 0; i < RECORD_LEN; i++) push(12'(i));
    chk("irq before done", bus.irq, 0);
    pulse_record_done();
    chk("irq after done", bus.irq, 1);
    chk("fifo_idle pending", bus.fifo_idle, 0);
    for (int i = 0; i < 7; i++) begin
      rd(tbl[i].addr, d, ack);
      model_read(tbl[i].addr, e);
      chk({tbl[i].nm, " ack"}, ack, 1);
      chk(tbl[i].nm, d, tbl[i].exp);
    end

    // 2: full drain
    for (int i = 0; i < RECORD_LEN; i++) begin
      rd(3'd0, d, ack);
      model_read(3'd0, e);
      chk($sformatf("drain ack %0d", i), ack, 1);
      chk($sformatf("drain %0d", i), d, 16'(i));
      if (i == 0) chk("irq after first read", bus.irq, 0);
    end
    chk("drain fifo_idle", bus.fifo_idle, 1);
    chk_read("extra read", 3'd0, d);
    chk("extra read word", d, 16'hFFFF);
    chk_read("status after drain", 3'd5, d);
    chk("status after drain const", d, 16'h0000);

    // 3: timeout flush with no MCU reads
    for (int i = 0; i < RECORD_LEN; i++) push(12'(i) ^ 12'h5A5);
    pulse_record_done();
    chk("irq t3", bus.irq, 1);
    repeat (9) tick();
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.fifo_rd_en) seen++;
    end
    chk("no flush at 9 s", seen, 0);
    one_second_clk = 1'b1;
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) seen = 1;
    end
    chk("flush started at 10 s", seen, 1);
    chk("irq in flush", bus.irq, 0);
    one_second_clk = 1'b0;
    wait_idle("flush done", 6000);
    chk("fifo drained", rd_ptr == wr_ptr, 1);
    model_flush();
    chk_read("status after flush", 3'd5, d);
    chk("status after flush const", d, 16'h0010);

    // 4: missed record, then random reads against the model
    for (int i = 0; i < RECORD_LEN; i++) push(12'($urandom));
    pulse_record_done();
    for (int i = 0; i < 3; i++) chk_read("t4 data", 3'd0, d);
    chk_read("t4 words before", 3'd6, d);
    chk("t4 words before const", d, 16'd4093);
    pulse_record_done();
    chk_read("t4 words after", 3'd6, d);
    chk("t4 words after const", d, 16'd4093);
    chk_read("t4 status", 3'd5, d);
    chk("t4 missed", d[15:8], 8'd1);
    for (int i = 0; i < 300; i++) begin
      logic [2:0] a;
      a = ($urandom_range(2) == 0) ? 3'($urandom_range(7)) : 3'd0;
      repeat ($urandom_range(2)) @(negedge clk);
      if ($urandom_range(39) == 0) pulse_record_done();
      chk_read($sformatf("rand %0d a%0d", i, a), a, d);
    end
    repeat (10) tick();
    wait_idle("t4 flush done", 6000);
    model_flush();
    chk_read("t4 status end", 3'd5, d);

    // 5: premature empty
    for (int i = 0; i < 100; i++) push(12'($urandom));
    pulse_record_done();
    for (int i = 0; i < 101; i++)
      chk_read($sformatf("t5 read %0d", i), 3'd0, d);
    chk("t5 read 101", d, 16'hFFFF);
    chk_read("t5 status 1", 3'd5, d);
    chk("t5 underflow set", d[3], 1);
    chk_read("t5 status 2", 3'd5, d);
    chk("t5 underflow clear", d[3], 0);
    repeat (10) tick();
    wait_idle("t5 flush done", 200);
    model_flush();
    chk_read("t5 status end", 3'd5, d);

    // 6: reset mid-READ
    for (int i = 0; i < 50; i++) push(12'($urandom));
    pulse_record_done();
    for (int i = 0; i < 5; i++) chk_read("t6 data", 3'd0, d);
    bus.mcu_addr = 3'd0;
    bus.mcu_rd_stb = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("t6 rd_en in reset", bus.fifo_rd_en, 0);
    chk("t6 irq in reset", bus.irq, 0);
    repeat (3) @(negedge clk);
    chk("t6 rd_en held", bus.fifo_rd_en, 0);
    chk("t6 ack held", bus.mcu_rd_ack, 0);
    chk("t6 data held", bus.mcu_rd_data, 0);
    chk("t6 fifo_idle", bus.fifo_idle, 1);
    bus.mcu_rd_stb = 1'b0;
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk_read("t6 status", 3'd5, d);
    chk("t6 status const", d, 16'h0000);
    chk_read("t6 words", 3'd6, d);
    chk("t6 words const", d, 16'h0000);
    chk_read("t6 ts_sec", 3'd1, d);
    chk_read("t6 ts_sub", 3'd3, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/capture_fifo_mcu_reader.md
Name: capture_fifo_mcu_reader

Overview:
Downstream consumer of the per-channel capture FIFO filled by the AD9238 save-to-FIFO stage.
- Latches the capture start timestamp.
- Raises an interrupt to the MCU when a record completes.
- Serves timestamp, status and sample words over a strobed register read port.
- Pops the FIFO one word per data read.
- Drives the fifo_idle level back to the save stage.
- Flushes an unread record after a whole-second timeout so the save stage is never blocked.

Parameters:
RECORD_LEN, 4096, samples per record; must equal the save stage write count.
DATA_W, 12, ADC sample width.
TIMEOUT_S, 10, one-second edges without an MCU read before auto-flush.
CNT_W, 13, width of words_left; must satisfy 2^CNT_W > RECORD_LEN.

Ports:
clk_100m  in  1  system clock, 100 MHz.
reset_n  in  1  asynchronous, active-low reset.
start_time_flag  in  1  one-cycle pulse: capture started.
record_done  in  1  one-cycle pulse: RECORD_LEN words written to FIFO.
one_second_clk  in  1  PPS-derived square wave; rising edge = one second.
sec_cnt  in  32  free-running seconds counter.
subsec_cnt  in  27  sub-second 10 ns tick counter.
fifo_rd_data  in  DATA_W  show-ahead FIFO head word.
fifo_empty  in  1  FIFO empty.
fifo_rd_en  out  1  pop strobe.
fifo_idle  out  1  high: reader idle and FIFO empty.
mcu_rd_stb  in  1  one-cycle read strobe, already synchronised to clk_100m.
mcu_addr  in  3  register select.
mcu_rd_data  out  16  read data.
mcu_rd_ack  out  1  one-cycle acknowledge.
irq  out  1  level interrupt to the MCU.

Behaviour:
Reset values:
- All outputs 0, except fifo_idle, which is the combinational term (state==IDLE && fifo_empty).
- State IDLE; all counters 0; timestamp registers 0.

Timestamp latch:
- start_time_flag in IDLE latches sec_cnt and subsec_cnt into ts_sec and ts_sub.
- In any other state the pulse is ignored.

State machine (IDLE, PENDING, READ, FLUSH):
- IDLE -> PENDING on record_done. words_left <= RECORD_LEN; irq <= 1 on the next cycle.
- PENDING -> READ on the first addr-0 read; irq <= 0.
- READ -> IDLE when words_left reaches 0 after a pop.
- PENDING or READ -> FLUSH when idle_sec == TIMEOUT_S.
  - idle_sec increments on each one_second_clk rising edge, detected with a 2-FF synchroniser plus edge detect.
  - idle_sec clears on any mcu_rd_stb and on entry to PENDING.
  - On entry to FLUSH: irq <= 0; flush_cnt increments, saturating at 255.
- FLUSH: fifo_rd_en = !fifo_empty every cycle. FLUSH -> IDLE when fifo_empty.

Missed records:
- record_done outside IDLE increments missed_cnt (8-bit, saturating).
- State is otherwise unaffected.

Read port:
- Latency is exactly 1 cycle: on mcu_rd_stb at cycle N, mcu_rd_data is valid and mcu_rd_ack = 1 at N+1.
- mcu_rd_data holds its value until the next ack.
- Address map:
  - 0: data word.
  - 1: ts_sec[15:0].
  - 2: ts_sec[31:16].
  - 3: ts_sub[15:0].
  - 4: {5'b0, ts_sub[26:16]}.
  - 5: {missed_cnt, flush_cnt[3:0], underflow, irq, state[1:0]}, where state encoding is IDLE=0, PENDING=1, READ=2, FLUSH=3.
  - 6: {3'b0, words_left}.
  - 7: 16'h0000.
- Data read (addr 0) in PENDING or READ with !fifo_empty and words_left > 0:
  - mcu_rd_data <= {4'b0, fifo_rd_data}.
  - fifo_rd_en = 1 for the single cycle N.
  - words_left decrements by 1.
- Data read (addr 0) in IDLE, in FLUSH, with fifo_empty, or with words_left == 0:
  - Returns 16'hFFFF; no pop.
  - Sets sticky underflow, except in IDLE. underflow clears on an addr-5 read.
- Strobe coinciding with the transition into FLUSH: the strobe wins. idle_sec clears and the read is served.

Pop arbitration: fifo_rd_en is never asserted by both paths in one cycle; FLUSH excludes data reads.

Reset mid-operation: the block returns to IDLE immediately and does not drain the FIFO. The FIFO and the save stage share reset_n.

Decomposition:
- Package: address constants (ADDR_DATA .. ADDR_STATUS), state encoding, underflow word 16'hFFFF.
- One sub-module: sec_edge_det (2-FF synchroniser plus rising-edge pulse on one_second_clk).

Test Plan:
1. Timestamp and interrupt:
   - Stimulus: start_time_flag with sec_cnt = 0x00012345, subsec_cnt = 0x3ABCDEF; FIFO preloaded 0..4095; record_done.
   - Required: irq = 1 one cycle later.
   - Required: addr 1/2/3/4 read 0x2345 / 0x0001 / 0xCDEF / 0x03AB.
2. Full data drain:
   - Stimulus: 4096 addr-0 reads.
   - Required: mcu_rd_data = 0x0000..0x0FFF in order, ack at N+1, irq = 0 after the first read.
   - Required: state returns to IDLE, fifo_idle = 1.
   - Required: a 4097th read returns 0xFFFF with underflow = 0.
3. Timeout flush:
   - Stimulus: record_done, no MCU reads, 10 one_second_clk edges.
   - Required: FLUSH is entered, FIFO pops until empty, flush_cnt = 1, irq = 0.
   - Required: IDLE is reached with fifo_idle = 1.
4. Missed record:
   - Stimulus: a second record_done during READ.
   - Required: missed_cnt = 1 in the addr-5 read; words_left is unchanged.
5. Premature empty:
   - Stimulus: FIFO holding 100 words; record_done; 101 data reads.
   - Required: read 101 returns 0xFFFF; addr 5 shows underflow = 1; the next addr-5 read shows underflow = 0.
6. Reset mid-operation:
   - Stimulus: reset_n asserted mid-READ.
   - Required: irq = 0, fifo_rd_en = 0, state IDLE, counters 0 while reset is held.
